ex_mdu_sequencer: RTL and testbench

- Iterative multiply/divide unit for the EX stage of the 64-bit pipelined core; executes RV64M ops alongside the single-cycle ALU.
- Sequences a radix-2 shift-add multiplier and restoring divider over XLEN cycles.
- Asserts stall to freeze IF/ID/ID-EX while it works, then presents one result for the EX/MEM register.
- Operates on already-forwarded operands; tracks the destination register across the multi-cycle operation.

---
 rtl/ex_mdu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_ex_mdu_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu_sequencer.sv
// ex_mdu_sequencer: iterative RV64M multiply/divide sequencer for the EX stage.
// Optional feature macro MDU_EARLY_OUT_EN: multiplies with a zero operand skip the iteration phase.
module ex_mdu_sequencer #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  input  logic [4:0]      id_ex_rd,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      ex_mem_rd,
  output logic            dbz
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          op_r;
  logic [4:0]          rd_r;
  logic [2*XLEN-1:0]   acc, acc_next;
  logic [XLEN-1:0]     opnd;
  logic                sign_q, sign_r;

  logic                is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic                div_by_zero, early_out;
  logic [XLEN-1:0]     special_res;
  logic                load, iterate, finish, take_special;

  // Operand conditioning: iterate on magnitudes, remember the sign to restore at the end.
  always_comb begin
    is_div      = op[2];
    a_signed    = is_div ? ~op[0] : (op[1:0] != 2'b11);
    b_signed    = is_div ? ~op[0] : ~op[1];
    a_neg       = a_signed & operandA[XLEN-1];
    b_neg       = b_signed & operandB[XLEN-1];
    abs_a       = a_neg ? -operandA : operandA;
    abs_b       = b_neg ? -operandB : operandB;
    div_by_zero = is_div && (operandB == '0);
`ifdef MDU_EARLY_OUT_EN
    early_out   = !is_div && ((operandA == '0) || (operandB == '0));
`else
    early_out   = 1'b0;
`endif
    special_res = '0;
    if (div_by_zero) special_res = op[1] ? operandA : '1;
  end

  // One iteration: acc holds {product_hi, multiplier} or {remainder, quotient}.
  logic [XLEN:0] mul_sum, div_shift, div_diff;
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (op_r[2]) begin
      if (div_diff[XLEN]) acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else                acc_next = {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, final_res;
  always_comb begin
    prod = sign_q ? -acc_next : acc_next;
    quo  = sign_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem  = sign_r ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    case (op_r)
      3'b000:                 final_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo;
      default:                final_res = rem;
    endcase
  end

  always_comb begin
    state_next   = state;
    load         = 1'b0;
    iterate      = 1'b0;
    finish       = 1'b0;
    take_special = 1'b0;
    stall        = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          stall = 1'b1;
          if (div_by_zero || early_out) begin
            state_next   = DONE;
            take_special = 1'b1;
          end else begin
            state_next = CALC;
            load       = 1'b1;
          end
        end
      end
      CALC: begin
        stall = 1'b1;
        if (flush) begin
          state_next = IDLE;
        end else begin
          iterate = 1'b1;
          if (cnt == '0) begin
            state_next = DONE;
            finish     = 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_r      <= '0;
      rd_r      <= '0;
      acc       <= '0;
      opnd      <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      ex_mem_rd <= '0;
      dbz       <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
      if (load) begin
        op_r   <= op;
        rd_r   <= id_ex_rd;
        acc    <= {{XLEN{1'b0}}, abs_a};
        opnd   <= abs_b;
        sign_q <= a_neg ^ b_neg;
        sign_r <= a_neg;
        cnt    <= CNT_W'(XLEN - 1);
      end
      if (iterate) begin
        acc <= acc_next;
        cnt <= cnt - 1'b1;
      end
      // Result, rd and flag only change on entry to DONE, so they hold otherwise.
      if (finish) begin
        result    <= final_res;
        ex_mem_rd <= rd_r;
        dbz       <= 1'b0;
      end
      if (take_special) begin
        result    <= special_res;
        ex_mem_rd <= id_ex_rd;
        dbz       <= div_by_zero;
      end
    end
  end

endmodule

// File: tb/tb_ex_mdu_sequencer.sv
// tb_ex_mdu_sequencer: directed and randomized checks of ex_mdu_sequencer against
// an arithmetic reference model of the RV64M operations.
module tb_ex_mdu_sequencer;

  localparam int XLEN = 64;
`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY_OUT_EN = 1'b1;
`else
  localparam bit EARLY_OUT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, start, flush;
  logic [2:0]      op;
  logic [XLEN-1:0] operandA, operandB;
  logic [4:0]      id_ex_rd;
  logic            stall, busy, done, dbz;
  logic [XLEN-1:0] result;
  logic [4:0]      ex_mem_rd;

  always #5 clk = ~clk;

  ex_mdu_sequencer #(.XLEN(XLEN), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB), .id_ex_rd(id_ex_rd), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result),
    .ex_mem_rd(ex_mem_rd), .dbz(dbz)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_res;
  logic        exp_dbz;
  int          exp_lat;
  logic [4:0]  exp_rd;
  int          cycles;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model_result(input logic [2:0] f, input logic [63:0] a,
                                               input logic [63:0] b);
    logic signed [127:0] sa, sb, ub, p;
    logic signed [63:0]  x, y;
    logic [127:0]        up;
    logic [63:0]         res;
    logic                ovf;
    sa  = {{64{a[63]}}, a};
    sb  = {{64{b[63]}}, b};
    ub  = {64'b0, b};
    x   = a;
    y   = b;
    up  = {64'b0, a} * {64'b0, b};
    ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    res = '0;
    case (f)
      3'd0: begin p = sa * sb; res = p[63:0];   end
      3'd1: begin p = sa * sb; res = p[127:64]; end
      3'd2: begin p = sa * ub; res = p[127:64]; end
      3'd3: res = up[127:64];
      3'd4: res = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (ovf ? a : 64'(x / y));
      3'd5: res = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      3'd6: res = (b == 0) ? a : (ovf ? 64'd0 : 64'(x % y));
      default: res = (b == 0) ? a : a % b;
    endcase
    return res;
  endfunction

  function automatic int model_latency(input logic [2:0] f, input logic [63:0] a,
                                       input logic [63:0] b);
    if (f[2] && b == 0) return 1;
    if (EARLY_OUT_EN && !f[2] && (a == 0 || b == 0)) return 1;
    return XLEN + 1;
  endfunction

  task automatic applyStimulus(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] rd);
    exp_res  = model_result(f, a, b);
    exp_dbz  = f[2] && (b == 0);
    exp_lat  = model_latency(f, a, b);
    exp_rd   = rd;
    op       = f;
    operandA = a;
    operandB = b;
    id_ex_rd = rd;
    start    = 1'b1;
    #1;
    compare("stall_at_start", 64'(stall), 64'd1);
    step();
    start    = 1'b0;
    op       = 3'($urandom);
    operandA = {$urandom, $urandom};
    operandB = {$urandom, $urandom};
    id_ex_rd = 5'($urandom);
    cycles   = 1;
  endtask

  task automatic checkOutput(input string tag, input bit start_in_done);
    if (exp_lat > 1) begin
      compare({tag, " busy_calc"}, 64'(busy), 64'd1);
      compare({tag, " stall_calc"}, 64'(stall), 64'd1);
    end
    while (done !== 1'b1 && cycles < 200) begin
      step();
      cycles++;
    end
    compare({tag, " latency"}, 64'(cycles), 64'(exp_lat));
    compare({tag, " result"}, result, exp_res);
    compare({tag, " rd"}, 64'(ex_mem_rd), 64'(exp_rd));
    compare({tag, " dbz"}, 64'(dbz), 64'(exp_dbz));
    compare({tag, " stall_done"}, 64'(stall), 64'd0);
    if (start_in_done) begin
      op       = 3'd5;
      operandB = '0;
      start    = 1'b1;
    end
    step();
    start = 1'b0;
    compare({tag, " busy_after"}, 64'(busy), 64'd0);
    compare({tag, " done_after"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [2:0]  f;
    logic [63:0] a, b;
    int          pulses;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
    operandA = '0; operandB = '0; id_ex_rd = '0;
    repeat (3) step();
    compare("reset busy", 64'(busy), 64'd0);
    compare("reset done", 64'(done), 64'd0);
    compare("reset stall", 64'(stall), 64'd0);
    compare("reset result", result, 64'd0);
    compare("reset rd", 64'(ex_mem_rd), 64'd0);
    compare("reset dbz", 64'(dbz), 64'd0);
    rst = 1'b0;
    step();

    applyStimulus(3'd0, 64'd10, 64'd5, 5'd1);
    checkOutput("mul_10x5", 1'b0);
    compare("mul_10x5 literal", result, 64'd50);
    applyStimulus(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2);
    checkOutput("mulh_m1xm1", 1'b1);
    applyStimulus(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3);
    checkOutput("mulhu_max_x2", 1'b0);
    applyStimulus(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4);
    checkOutput("div_m7_2", 1'b0);
    applyStimulus(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5);
    checkOutput("rem_m7_2", 1'b0);
    applyStimulus(3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6);
    checkOutput("div_overflow", 1'b0);
    applyStimulus(3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7);
    checkOutput("rem_overflow", 1'b0);
    applyStimulus(3'd5, 64'd9, 64'd0, 5'd8);
    checkOutput("divu_by_zero", 1'b1);
    applyStimulus(3'd7, 64'd9, 64'd0, 5'd9);
    checkOutput("remu_by_zero", 1'b0);
    applyStimulus(3'd0, 64'd0, 64'd123, 5'd10);
    checkOutput("mul_0x123", 1'b0);

    // Flush mid-multiply, then restart immediately in the following cycle.
    applyStimulus(3'd0, 64'd77, 64'd99, 5'd11);
    while (cycles < 20) begin
      step();
      cycles++;
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    compare("flush busy", 64'(busy), 64'd0);
    compare("flush done", 64'(done), 64'd0);
    applyStimulus(3'd2, 64'hFFFF_FFFF_FFFF_FF00, 64'd300, 5'd12);
    checkOutput("after_flush", 1'b0);

    op = 3'd0; operandA = 64'd3; operandB = 64'd4; start = 1'b1; flush = 1'b1;
    #1;
    compare("flush_idle stall", 64'(stall), 64'd0);
    step();
    start = 1'b0; flush = 1'b0;
    compare("flush_idle busy", 64'(busy), 64'd0);

    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(7));
      a = {$urandom, $urandom};
      if ($urandom_range(7) == 0) a = 64'h8000_0000_0000_0000;
      case ($urandom_range(3))
        0: b = {$urandom, $urandom};
        1: begin
          b = 64'($urandom_range(20, 1));
          if ($urandom_range(1) == 1) b = -b;
        end
        2: b = '0;
        default: b = 64'($urandom);
      endcase
      applyStimulus(f, a, b, 5'($urandom));
      checkOutput($sformatf("rand%0d_op%0d", i, f), 1'b0);
    end

    // Reset in the middle of a divide discards it entirely.
    applyStimulus(3'd5, 64'd100, 64'd7, 5'd13);
    while (cycles < 10) begin
      step();
      cycles++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    compare("midreset busy", 64'(busy), 64'd0);
    compare("midreset done", 64'(done), 64'd0);
    compare("midreset stall", 64'(stall), 64'd0);
    compare("midreset result", result, 64'd0);
    compare("midreset rd", 64'(ex_mem_rd), 64'd0);
    pulses = 0;
    repeat (80) begin
      step();
      if (done === 1'b1) pulses++;
    end
    compare("midreset no_done", 64'(pulses), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
